// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates the active-low row drive, debounces the first single key and reports {row_n, col_n}.
// Define KEYPAD_REPEAT_EN to pulse key_valid every REPEAT_CYCLES clocks while a key stays held.
module keypad_scanner #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_CYCLES   = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [7:0] location,
  output logic       key_valid,
  output logic       key_down
);

  localparam int MAXC = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  if (SCAN_DIV < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("keypad_scanner: SCAN_DIV >= 2, DEBOUNCE_CYCLES >= 1 and REPEAT_CYCLES >= 1 are required");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state;
  logic [3:0]    col_m;
  logic [3:0]    col_s;
  logic [CW-1:0] slot_cnt;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] rel_cnt;
  logic [7:0]    candidate;
  logic          single;
  logic          col_idle;
  logic [3:0]    row_next;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rpt_cnt;
`endif

  // Multi-key patterns (two or more zeros) are never treated as a key.
  assign single   = (col_s == 4'b1110) || (col_s == 4'b1101) ||
                    (col_s == 4'b1011) || (col_s == 4'b0111);
  assign col_idle = (col_s == 4'b1111);
  assign row_next = {row_n[2:0], row_n[3]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_m <= 4'b1111;
      col_s <= 4'b1111;
    end else begin
      col_m <= col_n;
      col_s <= col_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      row_n     <= 4'b1110;
      location  <= 8'hFF;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      candidate <= 8'hFF;
      slot_cnt  <= '0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            if (single) begin
              candidate <= {row_n, col_s};
              deb_cnt   <= '0;
              state     <= DEBOUNCE;
            end else begin
              row_n <= row_next;
            end
          end else begin
            slot_cnt <= slot_cnt + CW'(1);
          end
        end

        DEBOUNCE: begin
          if ({row_n, col_s} == candidate) begin
            if (deb_cnt == DEB_LAST) begin
              location  <= candidate;
              key_valid <= 1'b1;
              key_down  <= 1'b1;
              deb_cnt   <= '0;
              rel_cnt   <= '0;
              state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
              rpt_cnt   <= '0;
`endif
            end else begin
              deb_cnt <= deb_cnt + CW'(1);
            end
          end else begin
            deb_cnt  <= '0;
            slot_cnt <= '0;
            row_n    <= row_next;
            state    <= SCAN;
          end
        end

        HELD: begin
          // Roll-over to another column in this row only resets the release count.
          if (col_idle && rel_cnt == DEB_LAST) begin
            key_down <= 1'b0;
            rel_cnt  <= '0;
            slot_cnt <= '0;
            row_n    <= row_next;
            state    <= SCAN;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt  <= '0;
`endif
          end else begin
            rel_cnt <= col_idle ? rel_cnt + CW'(1) : '0;
`ifdef KEYPAD_REPEAT_EN
            if (rpt_cnt == RPT_LAST) begin
              rpt_cnt   <= '0;
              key_valid <= 1'b1;
            end else begin
              rpt_cnt <= rpt_cnt + RW'(1);
            end
`endif
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=40 and a matrix keypad model.
module tb_keypad_scanner;

  localparam int SDIV = 4;
  localparam int DEB  = 8;
  localparam int RPT  = 40;
`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_HOLD_PULSES = 4;
`else
  localparam int EXP_HOLD_PULSES = 1;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [7:0] location;
  logic       key_valid;
  logic       key_down;

  // press[r] holds the active-high column mask of keys held down in row r.
  logic [3:0] press [4];

  int total;
  int bad;

  keypad_scanner #(
    .SCAN_DIV       (SDIV),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .col_n    (col_n),
    .row_n    (row_n),
    .location (location),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) col_n = col_n & ~press[r];
    end
  end

  typedef struct {
    int         row;
    logic [3:0] cols;
    logic [7:0] exp_loc;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) press[r] = 4'b0000;
  endtask

  task automatic wait_release(input string name);
    int edges;
    edges = 0;
    while (key_down && edges < 60) begin
      tick();
      edges++;
    end
    chk(name, edges, 2 + DEB);
  endtask

  int         pulses;
  int         edges;
  int         lat;
  int         t;
  int         last_t;
  logic       ok;
  logic [3:0] rows_seen;
  logic [3:0] exp_row;
  logic [7:0] seen_loc;

  initial begin
    vecs[0] = '{row: 0, cols: 4'b0100, exp_loc: 8'b1110_1011};
    vecs[1] = '{row: 3, cols: 4'b0001, exp_loc: 8'b0111_1110};
    vecs[2] = '{row: 2, cols: 4'b0100, exp_loc: 8'b1011_1011};
    vecs[3] = '{row: 2, cols: 4'b0100, exp_loc: 8'b1011_1011};
    vecs[4] = '{row: 1, cols: 4'b0010, exp_loc: 8'b1101_1101};
    vecs[5] = '{row: 3, cols: 4'b1000, exp_loc: 8'b0111_0111};

    total = 0;
    bad   = 0;
    clk   = 1'b0;
    reset = 1'b1;
    clear_keys();
    tick();
    tick();

    chk("reset row_n", row_n, 4'b1110);
    chk("reset location", location, 8'hFF);
    chk("reset key_valid", key_valid, 0);
    chk("reset key_down", key_down, 0);
    reset = 1'b0;

    // Two keys in one row: never accepted, scanning keeps rotating.
    press[1] = 4'b0110;
    pulses = 0;
    rows_seen = 4'b0000;
    ok = 1'b1;
    repeat (80) begin
      tick();
      if (key_valid) pulses++;
      if ($countones(~row_n) != 1) ok = 1'b0;
      rows_seen = rows_seen | ~row_n;
    end
    chk("multi pulses", pulses, 0);
    chk("multi location", location, 8'hFF);
    chk("multi key_down", key_down, 0);
    chk("multi rows visited", rows_seen, 4'b1111);
    chk("multi one row low", ok, 1);
    clear_keys();
    repeat (10) tick();

    // Reset three clocks into DEBOUNCE, then exact first-press latency.
    reset = 1'b1;
    press[0] = 4'b0100;
    tick();
    tick();
    reset = 1'b0;
    ok = 1'b1;
    repeat (7) begin
      tick();
      if (key_valid || row_n != 4'b1110) ok = 1'b0;
    end
    chk("debounce frozen no pulse", ok, 1);
    reset = 1'b1;
    #1;
    chk("mid reset row_n", row_n, 4'b1110);
    chk("mid reset key_valid", key_valid, 0);
    chk("mid reset key_down", key_down, 0);
    chk("mid reset location", location, 8'hFF);
    tick();
    tick();
    reset = 1'b0;
    lat = -1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (key_valid && lat < 0) begin
        lat = e;
        seen_loc = location;
      end
      if (lat >= 0) break;
    end
    chk("first press latency", lat, 3 + 1 + DEB);
    chk("first press location", seen_loc, 8'b1110_1011);
    tick();
    chk("key_valid single cycle", key_valid, 0);
    chk("key_down after accept", key_down, 1);
    clear_keys();
    wait_release("reset test release");
    repeat (10) tick();

    // Table of single-key presses, including a repeated press of one key.
    for (int i = 0; i < 6; i++) begin
      clear_keys();
      press[vecs[i].row] = vecs[i].cols;
      pulses = 0;
      seen_loc = 8'h00;
      repeat (45) begin
        tick();
        if (key_valid) begin
          pulses++;
          seen_loc = location;
        end
      end
      exp_row = 4'b1111 ^ (4'b0001 << vecs[i].row);
      chk($sformatf("vec%0d pulses", i), pulses, 1);
      chk($sformatf("vec%0d location", i), seen_loc, vecs[i].exp_loc);
      chk($sformatf("vec%0d key_down held", i), key_down, 1);
      chk($sformatf("vec%0d row frozen", i), row_n, exp_row);
      clear_keys();
      wait_release($sformatf("vec%0d release", i));
      chk($sformatf("vec%0d location kept", i), location, vecs[i].exp_loc);
      repeat (10) tick();
    end

    // Bounce bursts of 5 clocks are too short to be accepted.
    pulses = 0;
    repeat (4) begin
      press[3] = 4'b0001;
      repeat (5) begin tick(); if (key_valid) pulses++; end
      clear_keys();
      repeat (5) begin tick(); if (key_valid) pulses++; end
    end
    chk("bounce no pulse", pulses, 0);
    chk("bounce location kept", location, 8'b0111_0111);
    press[3] = 4'b0001;
    pulses = 0;
    repeat (45) begin
      tick();
      if (key_valid) begin
        pulses++;
        seen_loc = location;
      end
    end
    chk("bounce stable pulses", pulses, 1);
    chk("bounce stable location", seen_loc, 8'b0111_1110);
    clear_keys();
    wait_release("bounce release");
    repeat (10) tick();

    // Long hold: one pulse, or acceptance plus repeats every RPT clocks.
    press[0] = 4'b0100;
    pulses = 0;
    for (int e = 0; e < 60; e++) begin
      tick();
      if (key_valid) begin
        pulses = 1;
        break;
      end
    end
    chk("hold accepted", pulses, 1);
    t = 0;
    last_t = 0;
    repeat (130) begin
      tick();
      t++;
      if (key_valid) begin
        pulses++;
        chk("repeat spacing", t - last_t, RPT);
        chk("repeat location", location, 8'b1110_1011);
        last_t = t;
      end
    end
    chk("hold pulse count", pulses, EXP_HOLD_PULSES);
    clear_keys();
    wait_release("hold release");
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
